// File: rtl/modexp_pkg.sv
// modexp_pkg: shared state encoding and width helper for the modular-exponentiation engine
package modexp_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, SCAN, SQR, MUL, DONE} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/mod_mul_serial.sv
// mod_mul_serial: bit-serial interleaved modular multiplier, p = a*b mod n, valid W cycles after go
import modexp_pkg::*;
module mod_mul_serial #(parameter int W = 1024) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] p,
  output logic         valid
);
  localparam int CW = cnt_w(W);
  logic [W+1:0] acc, prev, sum, red, nx, acc_n;
  logic [W-1:0] sh, bb, nn, sa;
  logic [CW-1:0] cnt;
  // the go edge already performs the first step on the live operands
  always_comb begin
    sa = go ? a : sh;
    nx = {2'b00, go ? n : nn};
    prev = go ? '0 : acc;
    sum = (prev << 1) + (sa[W-1] ? {2'b00, go ? b : bb} : '0);
    red = sum >= nx ? sum - nx : sum;
    acc_n = red >= nx ? red - nx : red;
  end
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      valid <= 1'b0;
    end else begin
      valid <= go ? W == 1 : cnt == CW'(1);
      if (go || cnt != '0) begin
        acc <= acc_n;
        sh <= sa << 1;
        cnt <= go ? CW'(W - 1) : cnt - CW'(1);
      end
      if (go) begin
        bb <= b;
        nn <= n;
      end
    end
  assign p = acc[W-1:0];
endmodule

// File: rtl/modexp_engine.sv
// modexp_engine: left-to-right square-and-multiply base^exp mod mod over one shared serial multiplier
import modexp_pkg::*;
module modexp_engine #(parameter int W = 1024, parameter int EW = W) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  base,
  input  logic [EW-1:0] exp,
  input  logic [W-1:0]  mod,
  output logic          ready,
  output logic          busy,
  output logic [W-1:0]  result,
  output logic          done,
  output logic          err
);
  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] ONE = CW'(1);
  state_t state, state_n;
  logic [W-1:0] base_r, mod_r, exp_r, r, r_n, ma, mb, p;
  logic [CW-1:0] i, i_n;
  logic err_n, go, valid, ebit, bad, last;
  assign ebit = exp_r[i[CW-2:0]];
  assign last = i == '0;
  assign bad = mod_r < W'(2) || base_r >= mod_r;
  assign ready = state == IDLE;
  assign busy = ~ready;
  assign done = state == DONE;
  assign result = r;
  mod_mul_serial #(.W(W)) u_mul (
    .clk(clk), .rst(rst), .go(go), .a(ma), .b(mb), .n(mod_r), .p(p), .valid(valid)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      r <= '0;
      i <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      r <= r_n;
      i <= i_n;
      err <= err_n;
      if (start && ready) begin
        base_r <= base;
        exp_r <= W'(exp);
        mod_r <= mod;
      end
    end
  // CHECK already inspects the top exponent bit; i going negative means no bit was set
  always_comb begin
    state_n = state;
    r_n = r;
    i_n = i;
    err_n = err;
    go = 1'b0;
    ma = p;
    mb = p;
    case (state)
      IDLE: if (start) begin
        state_n = CHECK;
        i_n = CW'(EW - 1);
        err_n = 1'b0;
      end
      CHECK, SCAN:
        if (state == CHECK && bad) begin
          state_n = DONE;
          err_n = 1'b1;
          r_n = '0;
        end else if (i[CW-1]) begin
          state_n = DONE;
          r_n = W'(1);
        end else if (!ebit) begin
          state_n = SCAN;
          i_n = i - ONE;
        end else begin
          r_n = base_r;
          go = !last;
          ma = base_r;
          mb = base_r;
          i_n = i - ONE;
          state_n = last ? DONE : SQR;
        end
      SQR: if (valid) begin
        r_n = p;
        go = ebit || !last;
        mb = ebit ? base_r : p;
        i_n = ebit ? i : i - ONE;
        state_n = ebit ? MUL : last ? DONE : SQR;
      end
      MUL: if (valid) begin
        r_n = p;
        go = !last;
        i_n = i - ONE;
        state_n = last ? DONE : SQR;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_modexp_engine.sv
// tb_modexp_engine: directed and randomized checks of modexp_engine against an arithmetic reference
module tb_modexp_engine;
  logic clk, rst;
  logic s_start, s_ready, s_busy, s_done, s_err;
  logic [15:0] s_base, s_exp, s_mod, s_result;
  logic l_start, l_ready, l_busy, l_done, l_err;
  logic [127:0] l_base, l_mod, l_result;
  logic [15:0] l_exp;
  int tests = 0, fails = 0, dones = 0;

  modexp_engine #(.W(16), .EW(16)) dut16 (
    .clk(clk), .rst(rst), .start(s_start), .base(s_base), .exp(s_exp), .mod(s_mod),
    .ready(s_ready), .busy(s_busy), .result(s_result), .done(s_done), .err(s_err)
  );
  modexp_engine #(.W(128), .EW(16)) dut128 (
    .clk(clk), .rst(rst), .start(l_start), .base(l_base), .exp(l_exp), .mod(l_mod),
    .ready(l_ready), .busy(l_busy), .result(l_result), .done(l_done), .err(l_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (s_done) dones++;

  function automatic logic [127:0] gold(input logic [127:0] b, input logic [15:0] e, input logic [127:0] m);
    logic [255:0] r, x, mm;
    mm = {128'b0, m};
    r = 256'd1 % mm;
    x = {128'b0, b} % mm;
    for (int k = 0; k < 16; k++) begin
      if (e[k]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[127:0];
  endfunction

  function automatic int lat_model(input logic [15:0] e, input int w, input bit bad);
    int t, pc;
    if (bad) return 2;
    if (e == 16'd0) return 18;
    t = 15;
    while (!e[t]) t--;
    pc = 0;
    for (int k = 0; k < t; k++) pc += int'(e[k]);
    return 2 + (15 - t) + w * (t + pc);
  endfunction

  task automatic run16(input logic [15:0] b, e, m, output logic [15:0] res, output logic er, output int lat);
    int g = 0;
    @(negedge clk);
    while (!s_ready && g < 5000) begin @(negedge clk); g++; end
    s_base = b; s_exp = e; s_mod = m; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_base = 16'($urandom); s_exp = 16'($urandom); s_mod = 16'($urandom);
    lat = 1;
    while (!s_done && lat < 5000) begin @(posedge clk); #1; lat++; end
    if (!s_done) lat = -1;
    res = s_result;
    er = s_err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", s_ready); end
    tests++; if (s_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", s_busy); end
    tests++; if (s_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", s_done); end
    tests++; if (s_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", s_err); end
    tests++; if (s_result !== 16'd0) begin fails++; $display("FAIL reset_result: got %0d expected 0", s_result); end
    tests++; if (l_ready !== 1'b1) begin fails++; $display("FAIL reset_ready128: got %b expected 1", l_ready); end
    rst = 1'b0;
  endtask

  task automatic test_pow13();
    logic [15:0] res; logic er; int lat;
    run16(16'd4, 16'd13, 16'd497, res, er, lat);
    tests++; if (res !== 16'd445) begin fails++; $display("FAIL pow13_result: got %0d expected 445", res); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL pow13_err: got %b expected 0", er); end
    tests++; if (lat !== 94) begin fails++; $display("FAIL pow13_latency: got %0d expected 94", lat); end
  endtask

  task automatic test_fermat();
    logic [15:0] res; logic er; int lat;
    run16(16'd2, 16'd65520, 16'd65521, res, er, lat);
    tests++; if (res !== 16'd1) begin fails++; $display("FAIL fermat_result: got %0d expected 1", res); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL fermat_err: got %b expected 0", er); end
    tests++; if (lat !== lat_model(16'd65520, 16, 1'b0)) begin fails++; $display("FAIL fermat_latency: got %0d expected %0d", lat, lat_model(16'd65520, 16, 1'b0)); end
  endtask

  task automatic test_exp_zero();
    logic [15:0] res; logic er; int lat;
    run16(16'd4, 16'd0, 16'd497, res, er, lat);
    tests++; if (res !== 16'd1) begin fails++; $display("FAIL exp0_result: got %0d expected 1", res); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL exp0_err: got %b expected 0", er); end
    tests++; if (lat !== 18) begin fails++; $display("FAIL exp0_latency: got %0d expected 18", lat); end
  endtask

  task automatic test_bad_operands();
    logic [15:0] res; logic er; int lat;
    run16(16'd0, 16'd5, 16'd1, res, er, lat);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL mod1_err: got %b expected 1", er); end
    tests++; if (res !== 16'd0) begin fails++; $display("FAIL mod1_result: got %0d expected 0", res); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL mod1_latency: got %0d expected 2", lat); end
    run16(16'd0, 16'd5, 16'd0, res, er, lat);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL mod0_err: got %b expected 1", er); end
    run16(16'd500, 16'd3, 16'd497, res, er, lat);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL bigbase_err: got %b expected 1", er); end
    tests++; if (res !== 16'd0) begin fails++; $display("FAIL bigbase_result: got %0d expected 0", res); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL bigbase_latency: got %0d expected 2", lat); end
    run16(16'd497, 16'd3, 16'd497, res, er, lat);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL base_eq_mod_err: got %b expected 1", er); end
    run16(16'd496, 16'd3, 16'd497, res, er, lat);
    tests++; if (res !== 16'(gold(128'd496, 16'd3, 128'd497))) begin fails++; $display("FAIL base_max_result: got %0d expected %0d", res, gold(128'd496, 16'd3, 128'd497)); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL base_max_err: got %b expected 0", er); end
  endtask

  task automatic test_busy_ignored();
    int lat, d0, g = 0;
    @(negedge clk);
    while (!s_ready && g < 5000) begin @(negedge clk); g++; end
    d0 = dones;
    s_base = 16'd4; s_exp = 16'd13; s_mod = 16'd497; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = 1;
    while (!s_done && lat < 5000) begin
      s_start = (lat % 17 == 5) && lat < 80;
      s_base = 16'd500; s_exp = 16'($urandom); s_mod = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    s_start = 1'b0;
    tests++; if (s_result !== 16'd445) begin fails++; $display("FAIL busy_result: got %0d expected 445", s_result); end
    tests++; if (lat !== 94) begin fails++; $display("FAIL busy_latency: got %0d expected 94", lat); end
    repeat (100) @(posedge clk);
    #1;
    tests++; if (dones !== d0 + 1) begin fails++; $display("FAIL busy_done_count: got %0d expected %0d", dones - d0, 1); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] res; logic er; int lat, d0;
    @(negedge clk);
    s_base = 16'd4; s_exp = 16'd13; s_mod = 16'd497; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (lat = 1; lat < 40; lat++) begin @(posedge clk); #1; end
    d0 = dones;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b expected 1", s_ready); end
    tests++; if (s_busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", s_busy); end
    tests++; if (s_result !== 16'd0) begin fails++; $display("FAIL abort_result: got %0d expected 0", s_result); end
    tests++; if (s_err !== 1'b0) begin fails++; $display("FAIL abort_err: got %b expected 0", s_err); end
    repeat (120) @(posedge clk);
    #1;
    tests++; if (dones !== d0) begin fails++; $display("FAIL abort_no_done: got %0d expected 0", dones - d0); end
    run16(16'd4, 16'd13, 16'd497, res, er, lat);
    tests++; if (res !== 16'd445) begin fails++; $display("FAIL abort_rerun_result: got %0d expected 445", res); end
    tests++; if (lat !== 94) begin fails++; $display("FAIL abort_rerun_latency: got %0d expected 94", lat); end
  endtask

  task automatic test_random16();
    logic [15:0] b, e, m, res; logic er; int lat;
    for (int k = 0; k < 4; k++) begin
      m = 16'($urandom_range(2, 65535));
      b = 16'($urandom % m);
      e = 16'($urandom);
      run16(b, e, m, res, er, lat);
      tests++; if (res !== 16'(gold(128'(b), e, 128'(m)))) begin fails++; $display("FAIL rand16_result: %0d^%0d mod %0d got %0d expected %0d", b, e, m, res, gold(128'(b), e, 128'(m))); end
      tests++; if (lat !== lat_model(e, 16, 1'b0)) begin fails++; $display("FAIL rand16_latency: got %0d expected %0d", lat, lat_model(e, 16, 1'b0)); end
    end
  endtask

  task automatic gen128(output logic [127:0] b, output logic [15:0] e, output logic [127:0] m);
    m = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
    if (m < 128'd3) m = 128'd3;
    b = {$urandom, $urandom, $urandom, $urandom} % m;
    e = 16'($urandom_range(1, 65535));
  endtask

  task automatic test_back_to_back128();
    logic [127:0] b, m; logic [15:0] e; int lat, g = 0;
    @(negedge clk);
    while (!l_ready && g < 5000) begin @(negedge clk); g++; end
    gen128(b, e, m);
    l_base = b; l_exp = e; l_mod = m; l_start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      l_start = 1'b0;
      lat = 1;
      while (!l_done && lat < 6000) begin @(posedge clk); #1; lat++; end
      tests++; if (l_result !== gold(b, e, m)) begin fails++; $display("FAIL rand128_result %0d: got %0h expected %0h", k, l_result, gold(b, e, m)); end
      tests++; if (l_err !== 1'b0) begin fails++; $display("FAIL rand128_err %0d: got %b expected 0", k, l_err); end
      tests++; if (lat !== lat_model(e, 128, 1'b0)) begin fails++; $display("FAIL rand128_latency %0d: got %0d expected %0d", k, lat, lat_model(e, 128, 1'b0)); end
      if (k < 5) begin
        gen128(b, e, m);
        l_base = b; l_exp = e; l_mod = m; l_start = 1'b1;
        @(posedge clk); #1;
        tests++; if (l_ready !== 1'b1) begin fails++; $display("FAIL rand128_ready_rise %0d: got %b expected 1", k, l_ready); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    s_start = 1'b0; s_base = '0; s_exp = '0; s_mod = '0;
    l_start = 1'b0; l_base = '0; l_exp = '0; l_mod = '0;
    test_reset();
    test_pow13();
    test_fermat();
    test_exp_zero();
    test_bad_operands();
    test_busy_ignored();
    test_reset_mid();
    test_random16();
    test_back_to_back128();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/modexp_engine.md
# modexp_engine

Parametrised modular-exponentiation engine computing result = base^exp mod mod with a bit-serial interleaved modular multiplier. It is the next-generation RSA core for the AES+RSA key-wrap path: it accepts independent modulus and exponent widths, uses a start/ready/done handshake, and reports invalid operands instead of producing garbage. The AES/RSA top instantiates it to wrap and unwrap the AES session key.

## Interface
- W, 1024: modulus, base and result width in bits.
- EW, W: exponent width in bits, 1 ≤ EW ≤ W.
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request. Accepted on the rising edge where start && ready.
- base, input, W: message or ciphertext. Must satisfy base < mod.
- exp, input, EW: exponent.
- mod, input, W: modulus. Must satisfy mod ≥ 2.
- ready, output, 1: engine idle; a request can be accepted.
- busy, output, 1: equals ~ready.
- result, output, W: last result. Held until the next accept.
- done, output, 1: one-cycle pulse; result and err are valid in that cycle.
- err, output, 1: operand error flag for the operation that just completed.

## Operation
- Reset values: ready=1, busy=0, done=0, err=0, result=0, FSM in IDLE.
- The engine latches base, exp and mod at accept. Inputs are don't-care afterwards.
- start while busy is ignored. Nothing is queued.
- FSM states:
  - IDLE: on accept, go to CHECK.
  - CHECK (1 cycle): if mod<2 or base≥mod, go to DONE with err=1 and result=0. Otherwise go to SCAN.
  - SCAN: one exponent bit per cycle, starting at bit EW-1, searching for the top set bit t.
    - If no bit is set after EW cycles, go to DONE with result=1.
    - Otherwise set R=base and go to SQR if t>0, else DONE.
  - SQR: R=R·R mod N, then go to MUL if exp[i]=1, else NEXT.
  - MUL: R=R·base mod N.
  - NEXT: i=i-1 (combinational step, zero cycles). Return to SQR while bits remain below t, else go to DONE.
  - DONE (1 cycle): drive result=R, pulse done, return to IDLE with ready=1.
- Modular multiply, A·B mod N with A,B<N:
  - Accumulator acc is W+2 bits, cleared at start of each multiply.
  - Exactly W cycles, scanning A from MSB to LSB.
  - Each cycle: acc=2·acc+(a_bit?B:0), then subtract N up to twice so acc<N.
  - Result width W, always <N.
- Arithmetic is unsigned throughout. No truncation is permitted before reduction.

## Timing
- Accept edge is cycle 0. CHECK is cycle 1. SCAN starts at cycle 2.
- Latency L from accept edge to the done-high cycle:
  - Valid, exp≠0: L = 2 + (EW-1-t) + W·(t + popcount(exp[t-1:0])).
  - exp=0: L = EW+2.
  - Operand error: L = 2.
- ready rises in the cycle after done. Back-to-back accept is possible on that edge.
- rst mid-operation returns to IDLE on the next edge: done=0, err=0, result=0. No done pulse is produced for the aborted operation.

## Structure
- Package modexp_pkg:
  - FSM state enum (IDLE, CHECK, SCAN, SQR, MUL, DONE).
  - Localparam helper for the counter width, $clog2(W)+1.
- Sub-module mod_mul_serial #(W):
  - Inputs: clk, rst, go, a, b, n.
  - Outputs: p, valid, with valid pulsing W cycles after go.
- The top FSM reuses one mod_mul_serial instance for both square and multiply.

## Test plan
- W=16, EW=16, base=4, exp=13, mod=497 → result=445, err=0, done at L=94.
- W=16, base=2, exp=65520, mod=65521 (Fermat) → result=1.
- exp=0, mod=497, base=4 → result=1 at L=EW+2. mod=1 → err=1, result=0 at L=2.
- base=500, mod=497 → err=1, result=0. Also pulse start again while busy: it is ignored, and exactly one done is observed.
- Assert rst at cycle 40 of the 4^13 run → ready=1, no done. A fresh request then returns 445.
- W=128, random operands (base<mod, odd mod) versus a golden model, back-to-back accepts on the cycle ready rises.
